dh_modexp_enc: RTL and testbench

- Parametrised successor of the round-1 DH encryption/verify stage.
- Computes key = base^exp mod p sequentially (left-to-right square-and-multiply) instead of a single-cycle power/divide.
- Verifies the peer's value (key ^ c1 must equal base) and emits c2 = key ^ r1.
- Sits between the key-exchange controller (start/done handshake) and the ciphertext path.

---
 rtl/dh_pkg.sv | 15 +
 rtl/dh_modexp_enc_if.sv | 23 ++
 rtl/dh_modmul.sv | 22 ++
 rtl/dh_modexp_enc.sv | 132 +++++++++++++
 tb/tb_dh_modexp_enc.sv | 111 +++++++++++
 5 files changed

// File: rtl/dh_pkg.sv
// Shared types and defaults for the DH modular-exponentiation stage.
// No logic here; latency/backpressure are defined by the users of these types.
package dh_pkg;
    localparam int   DW_DEF      = 8;
    localparam int   EW_DEF      = 8;
    localparam logic C2_RST_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SQR,
        MUL,
        CHECK,
        DONE
    } state_t;
endpackage

// File: rtl/dh_modexp_enc_if.sv
// Start/done request bundle between the key-exchange controller and the DH stage.
// Latency none (wires only); no backpressure, start is ignored while busy is high.
interface dh_modexp_enc_if #(
    parameter int DW = dh_pkg::DW_DEF,
    parameter int EW = dh_pkg::EW_DEF
);
    logic          start;
    logic [DW-1:0] base;
    logic [EW-1:0] exp;
    logic [DW-1:0] p;
    logic [DW-1:0] r1;
    logic [DW-1:0] c1;
    logic          busy;
    logic          done;
    logic          valid;
    logic          err;
    logic [DW-1:0] c2;

    modport master (output start, base, exp, p, r1, c1,
                    input  busy, done, valid, err, c2);
    modport slave  (input  start, base, exp, p, r1, c1,
                    output busy, done, valid, err, c2);
endinterface

// File: rtl/dh_modmul.sv
// Combinational a*b mod p on a full 2*DW-bit product; p==0 yields 0.
// Zero latency; no backpressure.
module dh_modmul
    import dh_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] p,
    output logic [DW-1:0] y
);
    logic [2*DW-1:0] prod;

    always_comb begin
        prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        y    = '0;
        if (p != '0) begin
            y = DW'(prod % {{DW{1'b0}}, p});
        end
    end
endmodule

// File: rtl/dh_modexp_enc.sv
// key = base^exp mod p (left-to-right square-and-multiply), verify key^c1==base, emit c2 = key^r1.
// Latency 2*EW+2 with DH_CONST_TIME_EN, else EW+popcount(exp)+2; p==0 finishes in 1; start ignored while busy.
module dh_modexp_enc
    import dh_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    dh_modexp_enc_if.slave bus
);
    localparam int CW = $clog2(EW + 1);

    state_t        state, state_nx;
    logic [DW-1:0] base_l, base_r, p_l, r1_l, c1_l, acc;
    logic [DW-1:0] base_mod, acc_init, mm_b, mm_y;
    logic [EW-1:0] exp_sh;
    logic [CW-1:0] cnt;
    logic          msb, last;
    logic          ld, do_sqr, do_mul, shift, do_chk, fin;
    logic          busy, done, valid, err;
    logic [DW-1:0] c2;

    assign msb  = exp_sh[EW-1];
    assign last = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.start) state_nx = (bus.p == '0) ? DONE : SQR;
`ifdef DH_CONST_TIME_EN
            SQR:   state_nx = MUL;
`else
            SQR:   state_nx = msb ? MUL : (last ? CHECK : SQR);
`endif
            MUL:   state_nx = last ? CHECK : SQR;
            CHECK: state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ld     = (state == IDLE) && bus.start;
        do_sqr = (state == SQR);
        do_mul = (state == MUL);
`ifdef DH_CONST_TIME_EN
        shift  = do_mul;
`else
        // a zero bit finishes in SQR, so the exponent advances there
        shift  = do_mul || (do_sqr && !msb);
`endif
        do_chk = (state == CHECK);
        fin    = (state == DONE);
    end

    assign base_mod = (bus.p == '0) ? '0 : bus.base % bus.p;
    assign acc_init = (bus.p == DW'(1)) ? '0 : DW'(1);
    assign mm_b     = do_mul ? (msb ? base_r : DW'(1)) : acc;

    dh_modmul #(.DW(DW)) u_modmul (
        .a (acc),
        .b (mm_b),
        .p (p_l),
        .y (mm_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            base_l <= '0;
            base_r <= '0;
            p_l    <= '0;
            r1_l   <= '0;
            c1_l   <= '0;
            acc    <= '0;
            exp_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            valid  <= 1'b0;
            err    <= 1'b0;
            c2     <= {DW{C2_RST_BIT}};
        end else begin
            done <= 1'b0;
            if (ld) begin
                base_l <= bus.base;
                base_r <= base_mod;
                p_l    <= bus.p;
                r1_l   <= bus.r1;
                c1_l   <= bus.c1;
                acc    <= acc_init;
                exp_sh <= bus.exp;
                cnt    <= CW'(EW);
                busy   <= 1'b1;
                valid  <= 1'b0;
                err    <= 1'b0;
                c2     <= '0;
            end
            if (do_sqr || do_mul) acc <= mm_y;
            if (shift) begin
                exp_sh <= exp_sh << 1;
                cnt    <= cnt - CW'(1);
            end
            if (do_chk) begin
                if ((acc ^ c1_l) == base_l) begin
                    c2    <= acc ^ r1_l;
                    valid <= 1'b1;
                end else begin
                    c2    <= '0;
                    valid <= 1'b0;
                end
            end
            if (fin) begin
                done <= 1'b1;
                busy <= 1'b0;
                err  <= (p_l == '0);
            end
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.valid = valid;
    assign bus.err   = err;
    assign bus.c2    = c2;
endmodule

// File: tb/tb_dh_modexp_enc.sv
// Directed bench for dh_modexp_enc with hand-computed keys and latencies.
module tb_dh_modexp_enc;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dh_modexp_enc_if #(.DW(8), .EW(8)) bus ();
    dh_modexp_enc #(.DW(8), .EW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int lat_of(input logic [7:0] e, input logic [7:0] pp);
        if (pp == 8'd0) return 1;
`ifdef DH_CONST_TIME_EN
        return 2 * 8 + 2;
`else
        return 8 + $countones(e) + 2;
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle where done is high.
    task automatic run(input string tag, input logic [7:0] b, input logic [7:0] e,
                       input logic [7:0] pp, input logic [7:0] r, input logic [7:0] c,
                       input logic ev, input logic ee, input logic [7:0] ec2, input logic poke);
        int  n;
        logic got;
        bus.base = b; bus.exp = e; bus.p = pp; bus.r1 = r; bus.c1 = c;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
        chk({tag, "_done_lo"}, 32'(bus.done), 32'd0);
        bus.base = ~b; bus.exp = ~e; bus.p = 8'hFD; bus.r1 = ~r; bus.c1 = ~c;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            bus.start = (poke && n == 3);
            if (bus.done) got = 1'b1;
        end
        bus.start = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'(lat_of(e, pp)));
        chk({tag, "_valid"}, 32'(bus.valid), 32'(ev));
        chk({tag, "_err"}, 32'(bus.err), 32'(ee));
        chk({tag, "_c2"}, 32'(bus.c2), 32'(ec2));
        chk({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        bus.start = 1'b0; bus.base = '0; bus.exp = '0; bus.p = '0; bus.r1 = '0; bus.c1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_c2", 32'(bus.c2), 32'hFF);
        rst = 1'b0;

        // 3^5 mod 7 = 5; 5^6 = 3 verifies; c2 = 5^0A
        run("t1", 8'd3, 8'd5, 8'd7, 8'h0A, 8'h06, 1'b1, 1'b0, 8'h0F, 1'b1);
        run("t2", 8'd3, 8'd5, 8'd7, 8'h0A, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        run("t3_p0", 8'd9, 8'h33, 8'd0, 8'h0A, 8'h11, 1'b0, 1'b1, 8'h00, 1'b0);
        run("t4_e0", 8'd4, 8'd0, 8'd7, 8'h0A, 8'h05, 1'b1, 1'b0, 8'h0B, 1'b0);
        // 2^10 mod 11 = 1
        run("t5", 8'd2, 8'd10, 8'd11, 8'h55, 8'h03, 1'b1, 1'b0, 8'h54, 1'b1);
        // 200^3 mod 251 = 128, products exceed 8 bits
        run("t6_wide", 8'd200, 8'd3, 8'd251, 8'h0F, 8'h48, 1'b1, 1'b0, 8'h8F, 1'b0);
        // p=1: key 0
        run("t7_p1", 8'd5, 8'h81, 8'd1, 8'h3C, 8'h05, 1'b1, 1'b0, 8'h3C, 1'b0);

        bus.base = 8'd3; bus.exp = 8'd5; bus.p = 8'd7; bus.r1 = 8'h0A; bus.c1 = 8'h06;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_c2", 32'(bus.c2), 32'hFF);
        chk("midrst_valid", 32'(bus.valid), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);

        run("t8_after_rst", 8'd3, 8'd5, 8'd7, 8'h0A, 8'h06, 1'b1, 1'b0, 8'h0F, 1'b0);
        @(posedge clk); #1;
        chk("t8_done_width", 32'(bus.done), 32'd0);
        chk("t8_c2_held", 32'(bus.c2), 32'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
